uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller that sequences the Uart_Receiver: drives its Rx_EN/baud_select, collects Rx_VALID bytes
//  into a show-ahead FIFO with valid/ready read side, counts framing/parity errors, flags idle gaps.
//  Baud changes are deferred until the line is idle so no frame is corrupted. Sits between receiver and host.
// PARAMETERS
//  FIFO_DEPTH   8       byte FIFO entries (power of 2)
//  ADDR_W       3       log2(FIFO_DEPTH)
//  IDLE_CYCLES  4480    clk cycles without Rx_VALID that define line idle (10 bits @ baud 3'b111, 50 MHz)
//  RST_BAUD     3'b111  baud_select value after reset
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-low
//  cfg_en       in   1       host enable; 0 forces OFF
//  cfg_wr       in   1       strobe: request baud change to cfg_baud
//  cfg_baud     in   3       requested baud code
//  err_clr      in   1       clears ferr_cnt, perr_cnt, overflow
//  Rx_DATA      in   8       byte from receiver
//  Rx_VALID     in   1       receiver byte strobe (1 cycle)
//  Rx_FERROR    in   1       framing error qualifying Rx_VALID
//  Rx_PERROR    in   1       parity error qualifying Rx_VALID
//  Rx_EN        out  1       receiver enable
//  baud_select  out  3       receiver baud code
//  rd_data      out  8       FIFO head
//  rd_valid     out  1       FIFO not empty
//  rd_ready     in   1       host pop
//  fifo_count   out  ADDR_W+1  occupancy 0..FIFO_DEPTH
//  overflow     out  1       sticky: byte dropped on full FIFO
//  ferr_cnt     out  8       framing errors, saturating at 255
//  perr_cnt     out  8       parity errors, saturating at 255
//  idle_flag    out  1       1-cycle pulse at idle after >=1 byte (message boundary)
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state OFF, Rx_EN=0, baud_select=RST_BAUD, FIFO empty, count/counters/overflow=0,
//   idle counter=0, pending reconfig cleared, idle_flag=0. Mid-operation reset discards FIFO contents.
//  FSM: OFF -> ARM when cfg_en=1. ARM: 2 cycles, Rx_EN=0, then ACTIVE. ACTIVE: Rx_EN=1 (registered).
//   ACTIVE -> ARM when pend && line_idle (baud_select<=pend_baud on entry). Any state -> OFF when cfg_en=0
//   (pend discarded, FIFO retained). Rx_EN high on 3rd edge after cfg_en first sampled 1.
//  cfg_wr: in OFF/ARM, baud_select<=cfg_baud next edge. In ACTIVE, latch pend_baud, set pend; later cfg_wr overwrites.
//  Idle counter: cleared on Rx_VALID and on ARM entry; increments in ACTIVE, saturates at IDLE_CYCLES.
//   line_idle = (counter==IDLE_CYCLES). idle_flag pulses on the cycle counter reaches IDLE_CYCLES if a byte
//   was accepted or errored since last pulse/ARM.
//  Rx_VALID ignored outside ACTIVE. In ACTIVE: FERROR -> ferr_cnt+1; PERROR -> perr_cnt+1 (both may increment);
//   any error -> byte dropped. Clean byte -> pushed.
//  FIFO: show-ahead; pop = rd_valid&rd_ready. Full & push & pop -> both occur, count unchanged. Full & push
//   & no pop -> byte dropped, overflow<=1. Empty: rd_data holds last value, rd_ready ignored. Pointers wrap mod DEPTH.
//  err_clr same cycle as error event: counter <= 1 (clear then count); overflow likewise re-set if drop.
//  Latency: clean Rx_VALID at edge N -> rd_valid=1, rd_data=byte after edge N (visible cycle N+1).
// TESTING
//  rst=0 2 cycles, cfg_en=1 -> Rx_EN 0,0 then 1 on 3rd edge; baud_select=3'b111 throughout.
//  Push 0xAA,0x55,0xCC,0xEE,0x4A with rd_ready=0 -> fifo_count=5; rd_ready=1 -> same order, rd_valid drops after 5 pops.
//  Rx_VALID with Rx_PERROR=1, data 0x4A -> perr_cnt=1, fifo_count unchanged; FERROR+PERROR -> both counters +1.
//  9 clean bytes, rd_ready=0 -> fifo_count=8, overflow=1, first 8 bytes read out; err_clr -> overflow=0.
//  cfg_wr baud 3'b011 just after a byte -> baud_select stays 3'b111 for 4480 cycles, idle_flag pulse,
//   Rx_EN low 2 cycles, baud_select=3'b011, Rx_EN back to 1.
//  rst=0 with 3 bytes queued and pend set -> next edge all outputs at reset values, rd_valid=0.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Host read port of the UART receive controller: show-ahead FIFO head plus occupancy.
interface uart_rx_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic [7:0]      rd_data;
   logic            rd_valid;
   logic            rd_ready;
   logic [ADDR_W:0] fifo_count;

   modport master (output rd_data, output rd_valid, output fifo_count, input rd_ready);
   modport slave  (input rd_data, input rd_valid, input fifo_count, output rd_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences receiver enable/baud, buffers clean bytes in a
// show-ahead FIFO, counts framing/parity errors and flags idle gaps on the line.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_OFF    | receiver disabled, waiting for cfg_en
// S_ARM    | two-cycle settle with Rx_EN low (power-up or after baud change)
// S_ACTIVE | receiver enabled, bytes accepted, deferred baud change pending
module uart_rx_ctrl #(
   parameter int         FIFO_DEPTH  = 8,
   parameter int         ADDR_W      = 3,
   parameter int         IDLE_CYCLES = 4480,
   parameter logic [2:0] RST_BAUD    = 3'b111
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cfg_en,
   input  logic         cfg_wr,
   input  logic [2:0]   cfg_baud,
   input  logic         err_clr,
   input  logic [7:0]   Rx_DATA,
   input  logic         Rx_VALID,
   input  logic         Rx_FERROR,
   input  logic         Rx_PERROR,
   output logic         Rx_EN,
   output logic [2:0]   baud_select,
   output logic         overflow,
   output logic [7:0]   ferr_cnt,
   output logic [7:0]   perr_cnt,
   output logic         idle_flag,
   uart_rx_ctrl_if.master rd_if
);

   localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
   localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_OFF, S_ARM, S_ACTIVE} state_t;

   state_t            state_q, state_d;
   logic              arm_cnt_q, arm_cnt_d;
   logic              rx_en_q, rx_en_d;
   logic              arm_entry, reconf, active, line_idle;
   logic [2:0]        baud_q, baud_d, pend_baud_q, pend_baud_d;
   logic              pend_q, pend_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              seen_q, seen_d, idle_flag_q, idle_flag_d;
   logic [7:0]        ferr_q, ferr_d, perr_q, perr_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rx_acc, push, pop, full, wr_en, drop, rd_valid_i;

   assign line_idle = (idle_cnt_q == IDLE_MAX);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_OFF;
      else      state_q <= state_d;
   end

   // Next-state logic; dropping cfg_en overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_OFF:    if (cfg_en) state_d = S_ARM;
         S_ARM:    if (arm_cnt_q == 1'b0) state_d = S_ACTIVE;
         S_ACTIVE: if (pend_q && line_idle) state_d = S_ARM;
         default:  state_d = S_OFF;
      endcase
      if (!cfg_en) state_d = S_OFF;
   end

   // FSM outputs: registered Rx_EN, ARM down-counter, transition strobes
   always_comb begin
      active    = (state_q == S_ACTIVE);
      arm_entry = (state_d == S_ARM) && (state_q != S_ARM);
      reconf    = (state_q == S_ACTIVE) && (state_d == S_ARM);
      rx_en_d   = (state_d == S_ACTIVE);
      arm_cnt_d = arm_cnt_q;
      if (arm_entry)                                 arm_cnt_d = 1'b1;
      else if (state_q == S_ARM && arm_cnt_q != 1'b0) arm_cnt_d = arm_cnt_q - 1'b1;
   end

   // Datapath: baud/pending reconfig, idle timer, error counters, FIFO
   always_comb begin
      rx_acc     = active && Rx_VALID;
      push       = rx_acc && !(Rx_FERROR || Rx_PERROR);
      rd_valid_i = (count_q != '0);
      pop        = rd_valid_i && rd_if.rd_ready;
      full       = (count_q == FULL);
      wr_en      = push && (!full || pop);
      drop       = push && full && !pop;

      baud_d      = baud_q;
      pend_d      = pend_q;
      pend_baud_d = pend_baud_q;
      if (reconf) begin
         baud_d = pend_baud_q;
         pend_d = 1'b0;
      end
      if (cfg_wr) begin
         if (active) begin
            pend_d      = 1'b1;
            pend_baud_d = cfg_baud;
         end else begin
            baud_d = cfg_baud;
         end
      end
      if (state_d == S_OFF) pend_d = 1'b0;

      idle_cnt_d = idle_cnt_q;
      if (arm_entry || Rx_VALID)           idle_cnt_d = '0;
      else if (active && !line_idle)       idle_cnt_d = idle_cnt_q + 1'b1;
      idle_flag_d = (idle_cnt_d == IDLE_MAX) && !line_idle && seen_q;
      seen_d = seen_q;
      if (rx_acc)                  seen_d = 1'b1;
      if (idle_flag_d || arm_entry) seen_d = 1'b0;

      // Clear applies first so a same-cycle event still counts
      ferr_d = err_clr ? 8'd0 : ferr_q;
      if (rx_acc && Rx_FERROR && ferr_d != 8'hFF) ferr_d = ferr_d + 8'd1;
      perr_d = err_clr ? 8'd0 : perr_q;
      if (rx_acc && Rx_PERROR && perr_d != 8'hFF) perr_d = perr_d + 8'd1;
      overflow_d = err_clr ? 1'b0 : overflow_q;
      if (drop) overflow_d = 1'b1;

      mem_d = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = Rx_DATA;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Registered head; bypass the incoming byte when it becomes the new head
      rd_data_d = rd_data_q;
      if (count_d != '0)
         rd_data_d = (wr_en && rd_ptr_d == wr_ptr_q) ? Rx_DATA : mem_q[rd_ptr_d];
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst) begin
         arm_cnt_q   <= 1'b0;
         rx_en_q     <= 1'b0;
         baud_q      <= RST_BAUD;
         pend_q      <= 1'b0;
         pend_baud_q <= RST_BAUD;
         idle_cnt_q  <= '0;
         seen_q      <= 1'b0;
         idle_flag_q <= 1'b0;
         ferr_q      <= 8'd0;
         perr_q      <= 8'd0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_data_q   <= 8'd0;
      end else begin
         arm_cnt_q   <= arm_cnt_d;
         rx_en_q     <= rx_en_d;
         baud_q      <= baud_d;
         pend_q      <= pend_d;
         pend_baud_q <= pend_baud_d;
         idle_cnt_q  <= idle_cnt_d;
         seen_q      <= seen_d;
         idle_flag_q <= idle_flag_d;
         ferr_q      <= ferr_d;
         perr_q      <= perr_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign Rx_EN            = rx_en_q;
   assign baud_select      = baud_q;
   assign overflow         = overflow_q;
   assign ferr_cnt         = ferr_q;
   assign perr_cnt         = perr_q;
   assign idle_flag        = idle_flag_q;
   assign rd_if.rd_data    = rd_data_q;
   assign rd_if.rd_valid   = rd_valid_i;
   assign rd_if.fifo_count = count_q;

endmodule
